// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM encoding and read-latency bounds for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W = $clog2(RD_LAT_MAX);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
endpackage

// File: rtl/load_store_unit_load_extend.sv
// lsu_load_extend: selects the addressed lane of a memory word and sign/zero-extends it
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  output logic [31:0] data
);
  logic [31:0] sh;
  assign sh = mem_rd >> {a, 3'b000};
  assign data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_BU ? {24'b0, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_HU ? {16'b0, sh[15:0]} : mem_rd;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one RV32I load/store request into a single word-aligned memory access
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misaligned,
  output logic        o_resp_illegal,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);
  localparam int LAT = RD_LATENCY < RD_LAT_MIN ? RD_LAT_MIN :
                       RD_LATENCY > RD_LAT_MAX ? RD_LAT_MAX : RD_LATENCY;
  state_e state, state_n;
  logic we_q, mis_q, ill_q;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q, rdata_q, ext;
  logic [CNT_W-1:0] cnt_q;
  logic ill_d, mis_d, issue, resp;
  assign ill_d = i_req_funct3 == 3'b011 || i_req_funct3[2:1] == 2'b11 || (i_req_we && i_req_funct3[2]);
  assign mis_d = !ill_d && (i_req_funct3[1:0] == 2'b01 ? i_req_addr[0] :
                            i_req_funct3[1:0] == 2'b10 && |i_req_addr[1:0]);
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !i_req_valid ? IDLE : (ill_d || mis_d) ? RESP : ISSUE;
      ISSUE:   state_n = we_q ? RESP : WAIT;
      WAIT:    state_n = cnt_q == '0 ? RESP : WAIT;
      default: state_n = i_resp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state == IDLE && i_req_valid) begin
        we_q    <= i_req_we;
        mis_q   <= mis_d;
        ill_q   <= ill_d;
        f3_q    <= i_req_funct3;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        rdata_q <= '0;
      end
      if (state == ISSUE)
        cnt_q <= CNT_W'(LAT - 1);
      if (state == WAIT) begin
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0)
          rdata_q <= ext;
      end
    end
  end
  lsu_load_extend u_ext (.mem_rd(i_mem_rd), .funct3(f3_q), .a(addr_q[1:0]), .data(ext));
  assign issue = state == ISSUE;
  assign resp  = state == RESP;
  assign o_req_ready       = state == IDLE;
  assign o_resp_valid      = resp;
  assign o_resp_rdata      = resp ? rdata_q : '0;
  assign o_resp_misaligned = resp && mis_q;
  assign o_resp_illegal    = resp && ill_q;
  assign o_mem_addr = issue ? {addr_q[31:2], 2'b00} : '0;
  assign o_mem_wd   = !issue ? '0 :
                      f3_q == F3_B ? {4{wdata_q[7:0]}} :
                      f3_q == F3_H ? {2{wdata_q[15:0]}} : wdata_q;
  assign o_mem_wen  = !(issue && we_q) ? 4'b0000 :
                      f3_q == F3_B ? 4'b0001 << addr_q[1:0] :
                      f3_q == F3_H ? 4'b0011 << addr_q[1:0] :
                      f3_q == F3_W ? 4'b1111 : 4'b0000;
  assign o_mem_ren  = issue && !we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: two LSUs (read latency 1 and 3) against a byte-level reference model and memory
module tb_load_store_unit;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid [N], req_we [N], resp_ready [N];
  logic [2:0] funct3 [N];
  logic [31:0] req_addr [N], req_wdata [N];
  logic req_ready [N], resp_valid [N], mis [N], ill [N], ren [N];
  logic [31:0] rdata [N], mem_addr [N], mem_wd [N], mem_rd [N];
  logic [3:0] wen [N];
  logic [31:0] mem [N][64];
  logic [31:0] ref_mem [N][64];
  logic [31:0] pipe [N][4];
  logic inflight [N];
  logic [31:0] exp_rd [N], exp_addr [N], exp_wd [N];
  logic [3:0] exp_wen [N];
  logic exp_mis [N], exp_ill [N];
  logic [31:0] last_addr [N], last_wd [N];
  logic [3:0] last_wen [N];
  int ren_cnt [N], wen_cnt [N];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int u);
    return u == 0 ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'h8BADF00D : 32'h11223344 + 32'(i) * 32'h01010101;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    load_store_unit #(.RD_LATENCY(g == 0 ? 1 : 3)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid[g]), .o_req_ready(req_ready[g]),
      .i_req_we(req_we[g]), .i_req_funct3(funct3[g]),
      .i_req_addr(req_addr[g]), .i_req_wdata(req_wdata[g]),
      .o_resp_valid(resp_valid[g]), .i_resp_ready(resp_ready[g]),
      .o_resp_rdata(rdata[g]), .o_resp_misaligned(mis[g]), .o_resp_illegal(ill[g]),
      .o_mem_addr(mem_addr[g]), .o_mem_wd(mem_wd[g]), .o_mem_wen(wen[g]),
      .o_mem_ren(ren[g]), .i_mem_rd(mem_rd[g])
    );
    assign mem_rd[g] = pipe[g][(g == 0 ? 1 : 3) - 1];
  end

  // Memory returns the word exactly RD_LATENCY cycles after ren; random junk on every other cycle.
  always @(posedge clk)
    for (int u = 0; u < N; u++) begin
      if (rst)
        for (int i = 0; i < 64; i++) mem[u][i] <= init_word(i);
      else
        for (int i = 0; i < 4; i++)
          if (wen[u][i]) mem[u][mem_addr[u][7:2]][8*i +: 8] <= mem_wd[u][8*i +: 8];
      pipe[u][0] <= ren[u] ? mem[u][mem_addr[u][7:2]] : $urandom;
      for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
    end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  // Reference: treats the access as size bytes at byte offset off within the word.
  function automatic void model(input bit we, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] word,
                                output bit m_ill, output bit m_mis, output logic [31:0] rd,
                                output logic [31:0] nword, output logic [31:0] ewd,
                                output logic [3:0] ewen);
    int size = f[1:0] == 2'd0 ? 1 : f[1:0] == 2'd1 ? 2 : 4;
    int off = int'(a[1:0]);
    logic [31:0] mask, v;
    m_ill = f == 3'd3 || f >= 3'd6 || (we && f >= 3'd4);
    m_mis = !m_ill && (off % size != 0);
    rd = 0; nword = word; ewd = 0; ewen = 0;
    if (!m_ill && !m_mis) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          ewd[8*i +: 8] = wd[8*(i % size) +: 8];
          if (i >= off && i < off + size) begin
            ewen[i] = 1'b1;
            nword[8*i +: 8] = wd[8*(i - off) +: 8];
          end
        end
      end else begin
        mask = size == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 1;
        v = (word >> (8 * off)) & mask;
        if (f < 3'd4 && size < 4 && v[8*size-1]) v = v | ~mask;
        rd = v;
      end
    end
  endfunction

  always @(negedge clk)
    if (!rst)
      for (int u = 0; u < N; u++) begin
        chk($sformatf("u%0d req_ready", u), req_ready[u], !inflight[u]);
        if (!inflight[u]) chk($sformatf("u%0d resp_valid_idle", u), resp_valid[u], 0);
        if (resp_valid[u]) begin
          chk($sformatf("u%0d rdata", u), rdata[u], exp_rd[u]);
          chk($sformatf("u%0d misaligned", u), mis[u], exp_mis[u]);
          chk($sformatf("u%0d illegal", u), ill[u], exp_ill[u]);
        end
        if (ren[u]) begin
          ren_cnt[u]++;
          chk($sformatf("u%0d ren_addr", u), mem_addr[u], exp_addr[u]);
        end
        if (wen[u] != 4'b0) begin
          wen_cnt[u]++;
          last_addr[u] = mem_addr[u]; last_wd[u] = mem_wd[u]; last_wen[u] = wen[u];
          chk($sformatf("u%0d wen_addr", u), mem_addr[u], exp_addr[u]);
          chk($sformatf("u%0d wd", u), mem_wd[u], exp_wd[u]);
          chk($sformatf("u%0d wen", u), wen[u], exp_wen[u]);
        end
      end

  task automatic txn(input int u, input bit we, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] g_rd, output logic g_mis, output logic g_ill);
    bit m_ill, m_mis;
    logic [31:0] rd_m, nw, ewd;
    logic [3:0] ewen;
    int n, r0, w0, lat;
    bit legal;
    model(we, f, a, wd, ref_mem[u][a[7:2]], m_ill, m_mis, rd_m, nw, ewd, ewen);
    legal = !m_ill && !m_mis;
    exp_rd[u] = rd_m; exp_mis[u] = m_mis; exp_ill[u] = m_ill;
    exp_addr[u] = {a[31:2], 2'b00}; exp_wd[u] = ewd; exp_wen[u] = ewen;
    lat = !legal ? 1 : we ? 2 : lat_of(u) + 2;
    r0 = ren_cnt[u]; w0 = wen_cnt[u];
    @(negedge clk);
    req_valid[u] = 1; req_we[u] = we; funct3[u] = f; req_addr[u] = a; req_wdata[u] = wd;
    @(posedge clk); #1;
    inflight[u] = 1;
    // keep a junk request asserted while busy; it must be ignored
    req_we[u] = 1'($urandom); funct3[u] = 3'($urandom); req_addr[u] = $urandom; req_wdata[u] = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid[u] && n < 40);
    if (!resp_valid[u]) begin
      n_cmp++; n_bad++;
      $display("FAIL u%0d response timeout: got none after %0d cycles, expected at %0d", u, n, lat);
      summary();
      $fatal(1, "response timeout");
    end
    chk($sformatf("u%0d latency", u), n, lat);
    g_rd = rdata[u]; g_mis = mis[u]; g_ill = ill[u];
    repeat (hold) @(negedge clk);
    resp_ready[u] = 1;
    @(posedge clk); #1;
    resp_ready[u] = 0; req_valid[u] = 0; inflight[u] = 0;
    chk($sformatf("u%0d ren_cycles", u), ren_cnt[u] - r0, (!we && legal) ? 1 : 0);
    chk($sformatf("u%0d wen_cycles", u), wen_cnt[u] - w0, (we && legal) ? 1 : 0);
    if (we && legal) ref_mem[u][a[7:2]] = nw;
  endtask

  initial begin
    logic [31:0] g;
    logic gm, gi;
    for (int u = 0; u < N; u++) begin
      req_valid[u] = 0; req_we[u] = 0; resp_ready[u] = 0; funct3[u] = 0;
      req_addr[u] = 0; req_wdata[u] = 0; inflight[u] = 0; ren_cnt[u] = 0; wen_cnt[u] = 0;
      for (int i = 0; i < 64; i++) ref_mem[u][i] = init_word(i);
    end
    @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < N; u++) begin
      chk("reset req_ready", req_ready[u], 1);
      chk("reset resp_valid", resp_valid[u], 0);
      chk("reset rdata", rdata[u], 0);
      chk("reset ren", ren[u], 0);
      chk("reset wen", wen[u], 0);
      chk("reset mem_addr", mem_addr[u], 0);
    end
    rst = 0;
    txn(0, 0, 3'b000, 32'h13, 0, 0, g, gm, gi); chk("LB 0x13", g, 32'hFFFFFF8B);
    txn(0, 0, 3'b100, 32'h13, 0, 0, g, gm, gi); chk("LBU 0x13", g, 32'h0000008B);
    txn(0, 0, 3'b001, 32'h12, 0, 0, g, gm, gi); chk("LH 0x12", g, 32'hFFFF8BAD);
    txn(0, 0, 3'b101, 32'h10, 0, 0, g, gm, gi); chk("LHU 0x10", g, 32'h0000F00D);
    txn(0, 0, 3'b010, 32'h10, 0, 0, g, gm, gi); chk("LW 0x10", g, 32'h8BADF00D);
    txn(0, 1, 3'b000, 32'h21, 32'h000000A5, 0, g, gm, gi);
    chk("SB mem_addr", last_addr[0], 32'h20);
    chk("SB mem_wd", last_wd[0], 32'hA5A5A5A5);
    chk("SB mem_wen", last_wen[0], 4'b0010);
    chk("SB rdata", g, 0);
    txn(0, 0, 3'b010, 32'h20, 0, 0, g, gm, gi); chk("LW 0x20 readback", g, 32'h192AA54C);
    txn(0, 1, 3'b001, 32'h13, 32'h1234, 0, g, gm, gi);
    chk("SH 0x13 misaligned", gm, 1); chk("SH 0x13 illegal", gi, 0);
    txn(0, 0, 3'b011, 32'h10, 0, 0, g, gm, gi);
    chk("f3=011 illegal", gi, 1); chk("f3=011 misaligned", gm, 0);
    txn(0, 1, 3'b101, 32'h13, 0, 0, g, gm, gi);
    chk("SHU 0x13 illegal", gi, 1); chk("SHU 0x13 misaligned", gm, 0);
    txn(0, 0, 3'b010, 32'h10, 0, 3, g, gm, gi); chk("LW held", g, 32'h8BADF00D);
    txn(1, 0, 3'b010, 32'h10, 0, 0, g, gm, gi); chk("L3 LW 0x10", g, 32'h8BADF00D);
    txn(1, 0, 3'b000, 32'h11, 0, 1, g, gm, gi); chk("L3 LB 0x11", g, 32'hFFFFFFF0);
    for (int u = 0; u < N; u++)
      for (int t = 0; t < 80; t++)
        txn(u, 1'($urandom), 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 2)), g, gm, gi);
    // abort a latency-3 load mid-wait
    exp_addr[1] = 32'h40;
    @(negedge clk);
    req_valid[1] = 1; req_we[1] = 0; funct3[1] = 3'b010; req_addr[1] = 32'h40;
    @(posedge clk); #1;
    inflight[1] = 1; req_valid[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    rst = 0; inflight[1] = 0;
    for (int u = 0; u < N; u++)
      for (int i = 0; i < 64; i++) ref_mem[u][i] = init_word(i);
    @(negedge clk);
    chk("abort ren", ren[1], 0);
    chk("abort resp_valid", resp_valid[1], 0);
    chk("abort req_ready", req_ready[1], 1);
    repeat (10) @(negedge clk);
    txn(1, 0, 3'b101, 32'h12, 0, 0, g, gm, gi); chk("post-reset LHU 0x12", g, 32'h00008BAD);
    summary();
    $finish;
  end
endmodule
